cac_issue_arbiter: RTL and testbench

Credit-based round-robin arbiter that shares one CaC compare-and-combine unit among NUM_REQ update producers. Each cycle it grants up to two requesters and drives them onto CaC lanes A and B. It meters issue against a downstream buffer credit pool, so CaC, which has no backpressure, never overruns the update sink. A flush sequence drains everything in flight before a phase boundary.

---
 rtl/cac_pkg.sv | 24 ++
 rtl/rr_first_pick.sv | 31 +++
 rtl/cac_issue_arbiter.sv | 139 +++++++++++++
 tb/tb_cac_issue_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cac_pkg.sv
// Shared types and helpers for the CaC issue arbiter: controller states,
// credit counter sizing and the registered lane record.
package cac_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } cac_state_e;

    localparam int CAC_DATA_W = 32;

    // Counter must hold the full pool value, hence CREDITS+1 codes.
    function automatic int credit_w(input int credits);
        return $clog2(credits + 1);
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [CAC_DATA_W-1:0] dest_vid;
        logic [CAC_DATA_W-1:0] update;
    } cac_lane_t;

endpackage

// File: rtl/rr_first_pick.sv
// First-set search over a request vector, starting at start_i and wrapping.
// N must be a power of two so the index wraps by truncation.
module rr_first_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [IW-1:0] probe;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        probe    = '0;
        for (int k = 0; k < N; k++) begin
            probe = start_i + IW'(k);
            if (!found_o && req_i[probe]) begin
                found_o  = 1'b1;
                idx_o    = probe;
                onehot_o = N'(1) << probe;
            end
        end
    end

endmodule

// File: rtl/cac_issue_arbiter.sv
// Credit-metered dual-issue round-robin arbiter feeding the two CaC lanes,
// with a flush sequence that waits for all credits to come home.
module cac_issue_arbiter
    import cac_pkg::*;
#(
    parameter  int DATA_W  = CAC_DATA_W,
    parameter  int NUM_REQ = 4,
    parameter  int CREDITS = 16,
    localparam int CW      = credit_w(CREDITS),
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        Req_Valid,
    input  logic [NUM_REQ*DATA_W-1:0] Req_DestVid,
    input  logic [NUM_REQ*DATA_W-1:0] Req_Update,
    output logic [NUM_REQ-1:0]        Req_Ready,
    output logic                      InputValid_A,
    output logic                      InputValid_B,
    output logic [DATA_W-1:0]         InDestVid_A,
    output logic [DATA_W-1:0]         InDestVid_B,
    output logic [DATA_W-1:0]         InUpdate_A,
    output logic [DATA_W-1:0]         InUpdate_B,
    input  logic                      Drain_A,
    input  logic                      Drain_B,
    input  logic                      Flush,
    output logic                      Flush_Done,
    output logic                      Idle,
    output logic                      Err,
    output logic [1:0]                Dbg_State,
    output logic [CW-1:0]             Dbg_Credits
);

    localparam int SW = CW + 1;

    cac_state_e    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] credits_q, credits_d;
    cac_lane_t     lane_a_q, lane_a_d, lane_b_q, lane_b_d;
    logic          err_q, err_d;

    logic [NUM_REQ-1:0] oh1, oh2;
    logic [IW-1:0]      idx1, idx2;
    logic               found1, found2;
    logic               gnt1, gnt2;
    logic [SW-1:0]      credit_sum;

    rr_first_pick #(.N(NUM_REQ)) u_pick1 (
        .req_i    (Req_Valid),
        .start_i  (rr_ptr_q),
        .onehot_o (oh1),
        .idx_o    (idx1),
        .found_o  (found1)
    );

    rr_first_pick #(.N(NUM_REQ)) u_pick2 (
        .req_i    (Req_Valid & ~oh1),
        .start_i  (idx1 + IW'(1)),
        .onehot_o (oh2),
        .idx_o    (idx2),
        .found_o  (found2)
    );

    // The credit pool caps how many of the two picks may actually issue.
    assign gnt1 = (state_q == RUN) && (credits_q != '0) && found1;
    assign gnt2 = (state_q == RUN) && (credits_q >= CW'(2)) && found1 && found2;

    assign Req_Ready = ({NUM_REQ{gnt1}} & oh1) | ({NUM_REQ{gnt2}} & oh2);

    assign Idle = (credits_q == CW'(CREDITS)) && !lane_a_q.valid && !lane_b_q.valid;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lane_a_d   = lane_a_q;
        lane_b_d   = lane_b_q;
        err_d      = err_q;
        credits_d  = credits_q;
        credit_sum = SW'(credits_q) - SW'(gnt1) - SW'(gnt2) + SW'(Drain_A) + SW'(Drain_B);

        case (state_q)
            RUN:     if (Flush) state_d = FLUSH;
            FLUSH:   if (Idle)  state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase

        lane_a_d.valid = gnt1;
        lane_b_d.valid = gnt2;
        if (gnt1) begin
            lane_a_d.dest_vid = CAC_DATA_W'(Req_DestVid[idx1*DATA_W +: DATA_W]);
            lane_a_d.update   = CAC_DATA_W'(Req_Update[idx1*DATA_W +: DATA_W]);
            rr_ptr_d          = idx1 + IW'(1);
        end
        if (gnt2) begin
            lane_b_d.dest_vid = CAC_DATA_W'(Req_DestVid[idx2*DATA_W +: DATA_W]);
            lane_b_d.update   = CAC_DATA_W'(Req_Update[idx2*DATA_W +: DATA_W]);
            rr_ptr_d          = idx2 + IW'(1);
        end

        // Issue never exceeds credits, so only the upper bound can be crossed.
        if (credit_sum > SW'(CREDITS)) begin
            credits_d = CW'(CREDITS);
            err_d     = 1'b1;
        end else begin
            credits_d = credit_sum[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            rr_ptr_q  <= '0;
            credits_q <= CW'(CREDITS);
            lane_a_q  <= '0;
            lane_b_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            credits_q <= credits_d;
            lane_a_q  <= lane_a_d;
            lane_b_q  <= lane_b_d;
            err_q     <= err_d;
        end
    end

    assign InputValid_A = lane_a_q.valid;
    assign InputValid_B = lane_b_q.valid;
    assign InDestVid_A  = DATA_W'(lane_a_q.dest_vid);
    assign InDestVid_B  = DATA_W'(lane_b_q.dest_vid);
    assign InUpdate_A   = DATA_W'(lane_a_q.update);
    assign InUpdate_B   = DATA_W'(lane_b_q.update);
    assign Flush_Done   = (state_q == DONE);
    assign Err          = err_q;
    assign Dbg_State    = state_q;
    assign Dbg_Credits  = credits_q;

endmodule

// File: tb/tb_cac_issue_arbiter.sv
// Bench for cac_issue_arbiter: directed scenarios with literal expectations,
// plus a cycle-by-cycle comparison against an integer-level reference model.
module tb_cac_issue_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int CR = 16;
    localparam int CW = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  req_valid = '0;
    logic [DW-1:0]  dv [NR];
    logic [DW-1:0]  up [NR];
    logic [NR*DW-1:0] req_dest, req_upd;
    logic           drain_a = 1'b0, drain_b = 1'b0, flush = 1'b0;

    logic [NR-1:0]  req_ready;
    logic           va, vb, flush_done, idle, err;
    logic [DW-1:0]  vid_a, vid_b, upd_a, upd_b;
    logic [1:0]     dbg_state;
    logic [CW-1:0]  dbg_credits;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign req_dest = {dv[3], dv[2], dv[1], dv[0]};
    assign req_upd  = {up[3], up[2], up[1], up[0]};

    cac_issue_arbiter #(.DATA_W(DW), .NUM_REQ(NR), .CREDITS(CR)) dut (
        .clk          (clk),
        .rst          (rst),
        .Req_Valid    (req_valid),
        .Req_DestVid  (req_dest),
        .Req_Update   (req_upd),
        .Req_Ready    (req_ready),
        .InputValid_A (va),
        .InputValid_B (vb),
        .InDestVid_A  (vid_a),
        .InDestVid_B  (vid_b),
        .InUpdate_A   (upd_a),
        .InUpdate_B   (upd_b),
        .Drain_A      (drain_a),
        .Drain_B      (drain_b),
        .Flush        (flush),
        .Flush_Done   (flush_done),
        .Idle         (idle),
        .Err          (err),
        .Dbg_State    (dbg_state),
        .Dbg_Credits  (dbg_credits)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 run, 1 flush, 2 done.
    int          m_ptr, m_credits, m_mode;
    bit          m_err, m_live, m_va, m_vb;
    logic [DW-1:0] m_da_vid, m_da_upd, m_db_vid, m_db_upd;

    function automatic void model_pick(input logic [NR-1:0] v, output int g1, output int g2);
        int lim;
        g1  = -1;
        g2  = -1;
        lim = (m_mode != 0) ? 0 : ((m_credits >= 2) ? 2 : m_credits);
        if (lim >= 1)
            for (int k = 0; k < NR; k++)
                if (g1 < 0 && v[(m_ptr + k) % NR]) g1 = (m_ptr + k) % NR;
        if (lim >= 2 && g1 >= 0)
            for (int k = 1; k < NR; k++)
                if (g2 < 0 && v[(g1 + k) % NR]) g2 = (g1 + k) % NR;
    endfunction

    function automatic logic [NR-1:0] model_ready(input logic [NR-1:0] v);
        int g1, g2;
        logic [NR-1:0] r;
        r = '0;
        model_pick(v, g1, g2);
        if (g1 >= 0) r[g1] = 1'b1;
        if (g2 >= 0) r[g2] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin : model_step
        int g1, g2, sum, issued;
        bit was_idle;
        if (rst) begin
            m_ptr = 0; m_credits = CR; m_mode = 0; m_err = 0;
            m_va = 0; m_vb = 0;
            m_da_vid = '0; m_da_upd = '0; m_db_vid = '0; m_db_upd = '0;
            m_live = 1;
        end else if (m_live) begin
            was_idle = (m_credits == CR) && !m_va && !m_vb;
            model_pick(req_valid, g1, g2);
            issued = 0;
            m_va = 0;
            m_vb = 0;
            if (g1 >= 0) begin
                m_va = 1; m_da_vid = dv[g1]; m_da_upd = up[g1];
                m_ptr = (g1 + 1) % NR; issued = 1;
            end
            if (g2 >= 0) begin
                m_vb = 1; m_db_vid = dv[g2]; m_db_upd = up[g2];
                m_ptr = (g2 + 1) % NR; issued = 2;
            end
            sum = m_credits - issued + int'(drain_a) + int'(drain_b);
            if (sum > CR) begin
                m_credits = CR;
                m_err = 1;
            end else begin
                m_credits = sum;
            end
            case (m_mode)
                0:       if (flush) m_mode = 1;
                1:       if (was_idle) m_mode = 2;
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("ready",      req_ready, model_ready(req_valid));
            check("valid_a",    va, m_va);
            check("valid_b",    vb, m_vb);
            check("vid_a",      vid_a, m_da_vid);
            check("upd_a",      upd_a, m_da_upd);
            check("vid_b",      vid_b, m_db_vid);
            check("upd_b",      upd_b, m_db_upd);
            check("idle",       idle, (m_credits == CR) && !m_va && !m_vb);
            check("err",        err, m_err);
            check("flush_done", flush_done, m_mode == 2);
            check("credits",    dbg_credits, m_credits);
            check("state",      dbg_state, m_mode);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            dv[i] = 32'h100 + i;
            up[i] = 32'hA0 + i;
        end

        // reset
        repeat (3) tick();
        rst = 1'b0;
        settle();
        check("rst_ready",   req_ready, 4'b0000);
        check("rst_va",      va, 1'b0);
        check("rst_vb",      vb, 1'b0);
        check("rst_vid_a",   vid_a, 32'h0);
        check("rst_idle",    idle, 1'b1);
        check("rst_err",     err, 1'b0);
        check("rst_credits", dbg_credits, 5'd16);
        check("rst_fdone",   flush_done, 1'b0);

        // sparse pair, then a lone requester
        tick(); req_valid = 4'b0101;
        settle(); check("pair_ready", req_ready, 4'b0101);
        tick(); req_valid = 4'b1000;
        settle();
        check("pair_va",    va, 1'b1);
        check("pair_vid_a", vid_a, 32'h100);
        check("pair_upd_a", upd_a, 32'hA0);
        check("pair_vb",    vb, 1'b1);
        check("pair_vid_b", vid_b, 32'h102);
        check("ptr3_ready", req_ready, 4'b1000);

        // full load with drains keeping pace
        tick(); req_valid = 4'b1111; drain_a = 1'b1; drain_b = 1'b1;
        settle();
        check("rr0_ready",  req_ready, 4'b0011);
        check("lone_vid_a", vid_a, 32'h103);
        check("lone_vb",    vb, 1'b0);
        check("net_credits", dbg_credits, 5'd13);
        tick(); settle(); check("rr1_ready", req_ready, 4'b1100);
        tick(); settle();
        check("rr2_ready",  req_ready, 4'b0011);
        check("rr2_vid_a",  vid_a, 32'h102);
        check("rr2_vid_b",  vid_b, 32'h103);
        tick(); req_valid = 4'b0000;
        tick(); drain_b = 1'b0;
        tick(); drain_a = 1'b0;
        settle();
        check("refill_credits", dbg_credits, 5'd16);
        check("refill_idle",    idle, 1'b1);

        // exhaust the pool, then return a single credit
        tick(); req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            settle();
            check("drain_down_ready", req_ready, (k % 2 == 0) ? 4'b1100 : 4'b0011);
            tick();
        end
        settle();
        check("empty_ready",   req_ready, 4'b0000);
        check("empty_credits", dbg_credits, 5'd0);
        tick(); drain_a = 1'b1;
        settle(); check("drain_cycle_ready", req_ready, 4'b0000);
        tick(); drain_a = 1'b0;
        settle(); check("one_credit_ready", req_ready, 4'b0100);
        tick(); settle();
        check("single_va",    va, 1'b1);
        check("single_vid_a", vid_a, 32'h102);
        check("single_vb",    vb, 1'b0);
        tick(); req_valid = 4'b0000; drain_a = 1'b1; drain_b = 1'b1;
        repeat (7) tick();
        tick(); drain_a = 1'b0; drain_b = 1'b0;
        settle(); check("full_again", dbg_credits, 5'd16);

        // flush with three updates in flight
        tick(); req_valid = 4'b0011;
        tick(); req_valid = 4'b0100;
        tick(); req_valid = 4'b0000; flush = 1'b1;
        tick(); flush = 1'b0; req_valid = 4'b1111; drain_a = 1'b1;
        settle();
        check("flush_ready",   req_ready, 4'b0000);
        check("flush_state",   dbg_state, 2'd1);
        check("flush_credits", dbg_credits, 5'd13);
        tick();
        tick();
        tick(); drain_a = 1'b0;
        settle();
        check("flush_idle",  idle, 1'b1);
        check("flush_nodone", flush_done, 1'b0);
        tick(); settle();
        check("done_pulse", flush_done, 1'b1);
        check("done_ready", req_ready, 4'b0000);
        tick(); settle();
        check("done_clear",   flush_done, 1'b0);
        check("resume_ready", req_ready, 4'b1001);

        // credit over-return
        tick(); req_valid = 4'b0000; drain_a = 1'b1; drain_b = 1'b1;
        tick();
        tick(); drain_a = 1'b0; drain_b = 1'b0;
        settle();
        check("err_set",     err, 1'b1);
        check("err_credits", dbg_credits, 5'd16);
        tick(); settle(); check("err_sticky", err, 1'b1);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        settle(); check("err_cleared", err, 1'b0);

        // mixed traffic with legal drains and occasional flushes
        for (int n = 0; n < 80; n++) begin
            tick();
            req_valid = NR'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) begin
                dv[i] = $urandom;
                up[i] = $urandom;
            end
            drain_a = (CR - m_credits >= 1) && ($urandom_range(0, 1) == 1);
            drain_b = (CR - m_credits >= 2) && ($urandom_range(0, 1) == 1);
            flush   = ($urandom_range(0, 15) == 0);
        end

        // reset while busy
        tick(); req_valid = 4'b1111; rst = 1'b1; flush = 1'b0;
        tick(); rst = 1'b0; req_valid = 4'b0000; drain_a = 1'b0; drain_b = 1'b0;
        settle();
        check("midrst_credits", dbg_credits, 5'd16);
        check("midrst_va",      va, 1'b0);
        check("midrst_state",   dbg_state, 2'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
